// File: rtl/tempo_pkg.sv
// Shared key codes and command encoding for the tempo controller slice.
package tempo_pkg;

  localparam logic [8:0] KEY_UP      = 9'h022;
  localparam logic [8:0] KEY_DOWN    = 9'h01A;
  localparam logic [8:0] KEY_DEFAULT = 9'h021;
  localparam logic [8:0] KEY_PAUSE   = 9'h029;

  typedef enum logic [2:0] {
    CMD_NONE,
    CMD_UP,
    CMD_DOWN,
    CMD_DEFAULT,
    CMD_PAUSE
  } key_cmd_e;

endpackage

// File: rtl/tempo_key_decoder.sv
// Maps a keyboard press event onto a tempo command; releases and unknown codes give CMD_NONE.
module tempo_key_decoder
  import tempo_pkg::*;
(
  input  logic [511:0] i_key_down,
  input  logic [8:0]   i_last_change,
  input  logic         i_key_valid,
  output key_cmd_e     o_cmd
);

  logic w_press;

  // A strobe only counts as a press when the changed key is now held.
  assign w_press = i_key_valid && i_key_down[i_last_change];

  always_comb begin
    o_cmd = CMD_NONE;
    if (w_press) begin
      case (i_last_change)
        KEY_UP:      o_cmd = CMD_UP;
        KEY_DOWN:    o_cmd = CMD_DOWN;
        KEY_DEFAULT: o_cmd = CMD_DEFAULT;
        KEY_PAUSE:   o_cmd = CMD_PAUSE;
        default:     o_cmd = CMD_NONE;
      endcase
    end
  end

endmodule

// File: rtl/tempo_controller.sv
// Keyboard-driven multi-level playback tempo generator (play_tick / play_clk).
// Optional pause on Space is enabled by defining TEMPO_CTRL_PAUSE_EN.
module tempo_controller
  import tempo_pkg::*;
#(
  parameter  int NUM_SPEEDS    = 4,
  parameter  int BASE_DIV_LOG2 = 22,
  parameter  int DEFAULT_SPEED = 1,
  localparam int SW            = ($clog2(NUM_SPEEDS) > 1) ? $clog2(NUM_SPEEDS) : 1
)(
  input  logic          clk,
  input  logic          rst,
  input  logic [511:0]  key_down,
  input  logic [8:0]    last_change,
  input  logic          key_valid,
  output logic [SW-1:0] speed,
  output logic          speed_changed,
  output logic          play_tick,
  output logic          play_clk,
  output logic          paused
);

  localparam logic [SW-1:0]            SPD_MAX = SW'(NUM_SPEEDS - 1);
  localparam logic [SW-1:0]            SPD_DEF = SW'(DEFAULT_SPEED);
  localparam logic [BASE_DIV_LOG2-1:0] ONES    = '1;

  key_cmd_e                 w_cmd;
  logic [SW-1:0]            r_speed;
  logic [SW-1:0]            w_speed_next;
  logic                     r_speed_changed;
  logic                     r_play_tick;
  logic                     r_play_clk;
  logic                     w_paused;
  logic [BASE_DIV_LOG2-1:0] r_cnt;
  logic [BASE_DIV_LOG2-1:0] w_mask;
  logic [BASE_DIV_LOG2-1:0] w_msb;
  logic                     w_wrap;

  tempo_key_decoder u_key_decoder (
    .i_key_down    (key_down),
    .i_last_change (last_change),
    .i_key_valid   (key_valid),
    .o_cmd         (w_cmd)
  );

  always_comb begin
    w_speed_next = r_speed;
    case (w_cmd)
      CMD_UP:      if (r_speed != SPD_MAX) w_speed_next = r_speed + SW'(1);
      CMD_DOWN:    if (r_speed != '0)      w_speed_next = r_speed - SW'(1);
      CMD_DEFAULT: w_speed_next = SPD_DEF;
      default:     w_speed_next = r_speed;
    endcase
  end

  // Low P = BASE_DIV_LOG2 - speed bits of the counter form the active period.
  assign w_mask = ONES >> r_speed;
  assign w_msb  = w_mask ^ (w_mask >> 1);
  assign w_wrap = &(r_cnt | ~w_mask);

`ifdef TEMPO_CTRL_PAUSE_EN
  logic r_paused;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_paused <= 1'b0;
    end else if (w_cmd == CMD_PAUSE) begin
      r_paused <= ~r_paused;
    end
  end

  assign w_paused = r_paused;
`else
  assign w_paused = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_speed         <= SPD_DEF;
      r_speed_changed <= 1'b0;
      r_cnt           <= '0;
      r_play_tick     <= 1'b0;
      r_play_clk      <= 1'b0;
    end else begin
      r_speed         <= w_speed_next;
      r_speed_changed <= (w_speed_next != r_speed);
      r_play_tick     <= !w_paused && w_wrap;
      // Counter is never cleared on a speed change so the tempo stays phase-continuous.
      if (!w_paused) begin
        r_cnt      <= r_cnt + 1'b1;
        r_play_clk <= |(r_cnt & w_msb);
      end
    end
  end

  assign speed         = r_speed;
  assign speed_changed = r_speed_changed;
  assign play_tick     = r_play_tick;
  assign play_clk      = r_play_clk;
  assign paused        = w_paused;

endmodule
